// File: rtl/fx_pkg.sv
// Shared fixed-point helpers for the saturating add/sub datapath: format arithmetic
// (aligned fraction/integer widths, difference width, rounding shift) and clamp limits.
package fx_pkg;

  function automatic int unsigned fx_max(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

  // Fraction bits of the common aligned format.
  function automatic int unsigned fx_frac_bits(input int unsigned a_frac,
                                               input int unsigned b_frac);
    return fx_max(a_frac, b_frac);
  endfunction

  // Integer bits (including sign) of the common aligned format.
  function automatic int unsigned fx_int_bits(input int unsigned a_w, input int unsigned a_frac,
                                              input int unsigned b_w, input int unsigned b_frac);
    return fx_max(a_w - a_frac, b_w - b_frac);
  endfunction

  // One extra bit makes a +/- b of aligned operands exact.
  function automatic int unsigned fx_diff_w(input int unsigned i_bits, input int unsigned f_bits);
    return i_bits + f_bits + 1;
  endfunction

  // Right shift that drops the surplus fraction bits of the result.
  function automatic int unsigned fx_shift(input int unsigned f_bits, input int unsigned c_frac);
    return f_bits - c_frac;
  endfunction

  function automatic longint fx_sat_max(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint fx_sat_min(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  // Clamp an integer value to the range of a w-bit two's-complement word.
  function automatic longint fx_sat_signed(input longint v, input int unsigned w);
    if (v > fx_sat_max(w)) return fx_sat_max(w);
    if (v < fx_sat_min(w)) return fx_sat_min(w);
    return v;
  endfunction

endpackage

// File: rtl/fx_sub_sat_if.sv
// Streaming operand/result bundle for the saturating subtractor, plus debug counter access.
interface fx_sub_sat_if #(
  parameter int unsigned A_W   = 8,
  parameter int unsigned B_W   = 6,
  parameter int unsigned C_W   = 5,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             out_valid;
  logic             out_ready;
  logic [C_W-1:0]   c;
  logic             c_sat;
  logic [CNT_W-1:0] sat_cnt;
  logic             cnt_clr;

  // Block side.
  modport slave (
    input  in_valid, a, b, out_ready, cnt_clr,
    output in_ready, out_valid, c, c_sat, sat_cnt
  );

  // Producer/consumer side.
  modport master (
    output in_valid, a, b, out_ready, cnt_clr,
    input  in_ready, out_valid, c, c_sat, sat_cnt
  );
endinterface

// File: rtl/fx_round_sat.sv
// Combinational round-half-up by S bits followed by clamp to a C_W-bit signed word.
module fx_round_sat import fx_pkg::*; #(
  parameter int unsigned D_W = 9,
  parameter int unsigned S   = 3,
  parameter int unsigned C_W = 5
) (
  input  logic signed [D_W-1:0] d_i,
  output logic signed [C_W-1:0] c_o,
  output logic                  sat_o
);
  localparam int unsigned RW = D_W - S + 1;
  localparam int unsigned XW = fx_max(RW, C_W) + 1;
  localparam logic signed [XW-1:0] SatMax = XW'(fx_sat_max(C_W));
  localparam logic signed [XW-1:0] SatMin = XW'(fx_sat_min(C_W));
  // 2^(S-1) for S>0, zero when there is nothing to round.
  localparam logic signed [D_W:0] Half = (D_W + 1)'((longint'(1) <<< S) >>> 1);

  logic signed [D_W:0]  sum;
  logic signed [RW-1:0] r;
  logic signed [XW-1:0] rx;

  // Round, widen, then clamp against the output range.
  always_comb begin
    sum   = {d_i[D_W-1], d_i} + Half;
    r     = RW'(sum >>> S);
    rx    = XW'(r);
    c_o   = rx[C_W-1:0];
    sat_o = 1'b0;
    if (rx > SatMax) begin
      c_o   = SatMax[C_W-1:0];
      sat_o = 1'b1;
    end else if (rx < SatMin) begin
      c_o   = SatMin[C_W-1:0];
      sat_o = 1'b1;
    end
  end
endmodule

// File: rtl/fx_sub_sat.sv
// Two-stage saturating fixed-point subtractor c = sat(round(a - b)) with valid/ready
// streaming and a sticky-at-max debug counter of saturated results.
module fx_sub_sat import fx_pkg::*; #(
  parameter int unsigned A_W    = 8,
  parameter int unsigned A_FRAC = 4,
  parameter int unsigned B_W    = 6,
  parameter int unsigned B_FRAC = 3,
  parameter int unsigned C_W    = 5,
  parameter int unsigned C_FRAC = 1,
  parameter int unsigned CNT_W  = 16
) (
  input logic        clk,
  input logic        rst,
  fx_sub_sat_if.slave bus
);
  localparam int unsigned F   = fx_frac_bits(A_FRAC, B_FRAC);
  localparam int unsigned I   = fx_int_bits(A_W, A_FRAC, B_W, B_FRAC);
  localparam int unsigned D_W = fx_diff_w(I, F);
  localparam int unsigned S   = fx_shift(F, C_FRAC);
  localparam logic [CNT_W-1:0] CntMax = '1;

  if (C_FRAC > F) begin : g_bad_cfrac
    $error("fx_sub_sat: C_FRAC must not exceed max(A_FRAC, B_FRAC)");
  end

  logic                  s1_valid_q, s1_valid_d;
  logic signed [D_W-1:0] d_q, d_d;
  logic                  out_valid_q, out_valid_d;
  logic [C_W-1:0]        c_q, c_d;
  logic                  c_sat_q, c_sat_d;
  logic [CNT_W-1:0]      sat_cnt_q, sat_cnt_d;

  logic                  adv;
  logic signed [D_W-1:0] a_al, b_al, diff;
  logic signed [C_W-1:0] rs_c;
  logic                  rs_sat;

  fx_round_sat #(
    .D_W(D_W),
    .S  (S),
    .C_W(C_W)
  ) u_round_sat (
    .d_i  (d_q),
    .c_o  (rs_c),
    .sat_o(rs_sat)
  );

  // Align both operands to Q(I).F; the difference is exact in D_W bits.
  always_comb begin
    a_al = D_W'($signed(bus.a)) <<< (F - A_FRAC);
    b_al = D_W'($signed(bus.b)) <<< (F - B_FRAC);
    diff = a_al - b_al;
  end

  // Single advance enable: the whole pipe moves unless a result is stuck at the output.
  always_comb begin
    adv          = !out_valid_q || bus.out_ready;
    bus.in_ready = adv;
    bus.out_valid = out_valid_q;
    bus.c        = c_q;
    bus.c_sat    = c_sat_q;
    bus.sat_cnt  = sat_cnt_q;
  end

  // Pipeline next state; stage 1 valid bit travels with its data.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    d_d         = d_q;
    out_valid_d = out_valid_q;
    c_d         = c_q;
    c_sat_d     = c_sat_q;
    if (adv) begin
      s1_valid_d  = bus.in_valid;
      out_valid_d = s1_valid_q;
      if (bus.in_valid) d_d = diff;
      if (s1_valid_q) begin
        c_d     = rs_c;
        c_sat_d = rs_sat;
      end
    end
  end

  // Counter next state: clear wins over a same-cycle saturated handshake.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (bus.cnt_clr) begin
      sat_cnt_d = '0;
    end else if (out_valid_q && bus.out_ready && c_sat_q && (sat_cnt_q != CntMax)) begin
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset drops all in-flight data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      c_sat_q     <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      c_sat_q     <= c_sat_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end
endmodule

// File: tb/tb_fx_sub_sat.sv
// Self-checking bench for fx_sub_sat: real-valued reference model with a result queue,
// per-cycle compare process, directed literal cases, backpressure, counter and reset tests.
module tb_fx_sub_sat;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fx_sub_sat_if #(.A_W(8), .B_W(6), .C_W(5), .CNT_W(16)) bus ();
  fx_sub_sat_if #(.A_W(8), .B_W(6), .C_W(5), .CNT_W(3))  bus_s ();

  // Second instance with a tiny counter shares all inputs, so it exercises the sticky limit.
  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.a         = bus.a;
  assign bus_s.b         = bus.b;
  assign bus_s.out_ready = bus.out_ready;
  assign bus_s.cnt_clr   = bus.cnt_clr;

  fx_sub_sat #(.A_W(8), .A_FRAC(4), .B_W(6), .B_FRAC(3), .C_W(5), .C_FRAC(1), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  fx_sub_sat #(.A_W(8), .A_FRAC(4), .B_W(6), .B_FRAC(3), .C_W(5), .C_FRAC(1), .CNT_W(3)) dut_s (
    .clk(clk),
    .rst(rst),
    .bus(bus_s)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int c;    // result in units of 0.5
    bit sat;
  } res_t;

  res_t   q[$];
  longint cnt_m = 0;
  longint cnt_s = 0;

  logic   last_in_ready, last_ov;
  logic [4:0] last_c;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Real-valued reference: a is Q4.4, b is Q3.3, result Q4.1 round-half-up, clamp -8..7.5.
  function automatic res_t model(input int av, input int bv);
    res_t r;
    real  x, y;
    x = real'(av) / 16.0 - real'(bv) / 8.0;
    y = $floor(x * 2.0 + 0.5);
    r.sat = 1'b0;
    if (y > 15.0) begin
      y = 15.0;
      r.sat = 1'b1;
    end else if (y < -16.0) begin
      y = -16.0;
      r.sat = 1'b1;
    end
    r.c = int'(y);
    return r;
  endfunction

  // Compare process: outputs and inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      cnt_m = 0;
      cnt_s = 0;
    end else begin
      chk("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
      chk("sat_cnt", bus.sat_cnt, cnt_m);
      chk("sat_cnt_small", bus_s.sat_cnt, cnt_s);
      chk("in_flight_le2", longint'(q.size() <= 2), 1);
      if (q.size() == 0) begin
        chk("no_unexpected_out_valid", bus.out_valid, 0);
      end else if (bus.out_valid) begin
        chk("c", $signed(bus.c), q[0].c);
        chk("c_sat", bus.c_sat, q[0].sat);
      end
      if (bus.cnt_clr) begin
        cnt_m = 0;
        cnt_s = 0;
      end else if (bus.out_valid && bus.out_ready && q.size() != 0 && q[0].sat) begin
        if (cnt_m < 65535) cnt_m++;
        if (cnt_s < 7) cnt_s++;
      end
      if (bus.out_valid && bus.out_ready && q.size() != 0) void'(q.pop_front());
      if (bus.in_valid && bus.in_ready) q.push_back(model($signed(bus.a), $signed(bus.b)));
    end
  end

  // One cycle of stimulus, starting and ending just after a rising edge.
  task automatic cyc(input logic v, input int av, input int bv, input logic ordy,
                     input logic clr, output logic acc);
    bus.in_valid  = v;
    bus.a         = av[7:0];
    bus.b         = bv[5:0];
    bus.out_ready = ordy;
    bus.cnt_clr   = clr;
    @(negedge clk);
    acc           = v && bus.in_ready;
    last_in_ready = bus.in_ready;
    last_ov       = bus.out_valid;
    last_c        = bus.c;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc(1'b0, 0, 0, 1'b1, 1'b0, acc);
    chk("drain_done", q.size(), 0);
    cyc(1'b0, 0, 0, 1'b1, 1'b0, acc);
  endtask

  // Isolated transaction with fixed latency check against hand-computed values.
  task automatic directed(input string nm, input int av, input int bv, input int exp_c,
                          input logic exp_sat);
    bus.out_ready = 1'b1;
    bus.cnt_clr   = 1'b0;
    bus.a         = av[7:0];
    bus.b         = bv[5:0];
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk({nm, "_not_yet"}, bus.out_valid, 0);
    @(posedge clk);
    #1;
    chk({nm, "_valid"}, bus.out_valid, 1);
    chk({nm, "_c"}, $signed(bus.c), exp_c);
    chk({nm, "_sat"}, bus.c_sat, exp_sat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   av, bv, idx;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    bus.cnt_clr   = 1'b0;

    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_c", bus.c, 0);
    chk("rst_c_sat", bus.c_sat, 0);
    chk("rst_sat_cnt", bus.sat_cnt, 0);
    #10 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);

    // Hand-computed cases.
    directed("sub_basic", 8'h30, -12, 9, 1'b0);
    directed("sat_pos", 127, -32, 15, 1'b1);
    chk("cnt_after_pos", bus.sat_cnt, 1);
    directed("sat_neg", -128, 31, -16, 1'b1);
    chk("cnt_after_neg", bus.sat_cnt, 2);
    directed("rnd_quarter", 4, 0, 1, 1'b0);
    directed("rnd_neg_quarter", -4, 0, 0, 1'b0);
    directed("rnd_eighth", 2, 0, 0, 1'b0);

    // Six back-to-back pairs with a three-cycle output stall.
    idx = 0;
    for (int k = 0; k < 30 && idx < 6; k++) begin
      logic ordy;
      ordy = !(k >= 3 && k <= 5);
      cyc(1'b1, idx * 20 - 50, 13 - idx * 5, ordy, 1'b0, acc);
      if (!ordy && last_ov) chk("bp_in_ready_low", last_in_ready, 0);
      if (k == 3) av = int'(last_c);
      if (k == 4 || k == 5) chk("bp_c_held", last_c, av);
      if (acc) idx++;
    end
    chk("bp_all_sent", idx, 6);
    drain();

    // Counter: clear, saturate past the small counter's limit, then clear on a sat handshake.
    cyc(1'b0, 0, 0, 1'b1, 1'b1, acc);
    for (int i = 0; i < 10; i++) cyc(1'b1, 127, -32, 1'b1, 1'b0, acc);
    drain();
    chk("cnt_ten", bus.sat_cnt, 10);
    chk("cnt_small_stuck", bus_s.sat_cnt, 7);
    cyc(1'b1, -128, 31, 1'b1, 1'b0, acc);
    cyc(1'b0, 0, 0, 1'b1, 1'b0, acc);
    chk("clr_pending_sat", last_ov, 0);
    cyc(1'b0, 0, 0, 1'b1, 1'b1, acc);
    chk("clr_coincident_ov", last_ov, 1);
    chk("clr_wins", bus.sat_cnt, 0);
    chk("clr_wins_small", bus_s.sat_cnt, 0);

    // Exhaustive a x b sweep with random backpressure, bubbles and rare clears.
    for (int ai = -128; ai < 128; ai++) begin
      for (int bi = -32; bi < 32; bi++) begin
        acc = 1'b0;
        while (!acc) begin
          if ($urandom_range(0, 7) == 0) begin
            cyc(1'b0, int'($urandom), int'($urandom), 1'($urandom_range(0, 3) != 0),
                1'b0, acc);
            acc = 1'b0;
          end
          cyc(1'b1, ai, bi, 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 299) == 0), acc);
        end
      end
    end
    drain();

    // Asynchronous reset in the middle of a saturating, stalled stream.
    for (int i = 0; i < 8; i++) cyc(1'b1, 127, -32, 1'($urandom_range(0, 1)), 1'b0, acc);
    chk("pre_rst_cnt_nonzero", longint'(bus.sat_cnt != 0), 1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_sat_cnt", bus.sat_cnt, 0);
    chk("mid_rst_c", bus.c, 0);
    chk("mid_rst_c_sat", bus.c_sat, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 0, 0, 1'b0, 1'b0, acc);
    chk("post_mid_rst_in_ready", last_in_ready, 1);
    chk("post_mid_rst_ov", last_ov, 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0, 1'b1, 1'b0, acc);
    directed("after_rst", 8'h30, -12, 9, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fx_sub_sat.md
# fx_sub_sat

Pipelined signed fixed-point saturating subtractor with valid/ready streaming handshake: computes c = sat(round(a − b)) from two differently-formatted two's-complement operands into a narrower output format. It is the inverse-direction companion to the team's saturating fixed-point adder and sits in the same datapath, on the error/residual path. It also keeps a per-sample saturation flag and a saturating event counter for debug.

## Interface
- A_W, 8, width of a (signed)
- A_FRAC, 4, fractional bits of a (default Q4.4)
- B_W, 6, width of b (signed)
- B_FRAC, 3, fractional bits of b (default Q3.3)
- C_W, 5, width of c (signed)
- C_FRAC, 1, fractional bits of c (default Q4.1); C_FRAC ≤ max(A_FRAC,B_FRAC) is required, elaboration error otherwise
- CNT_W, 16, width of saturation counter
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts operands this cycle
- a  in  A_W  minuend, signed
- b  in  B_W  subtrahend, signed
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- c  out  C_W  signed result
- c_sat  out  1  result was clamped
- sat_cnt  out  CNT_W  count of accepted saturated results
- cnt_clr  in  1  synchronous clear of sat_cnt

## Operation
- F = max(A_FRAC,B_FRAC); I = max(A_W−A_FRAC, B_W−B_FRAC); D_W = I+F+1.
- Stage 1: sign-extend and left-shift a, b to Q(I).F; d = a_al − b_al in D_W bits (exact, no overflow possible); register d.
- Stage 2: rounding is round-half-up: r = (d + 2^(S−1)) >>> S, S = F−C_FRAC (S=0: r = d, no rounding add); r width D_W−S+1.
- Saturation: r > 2^(C_W−1)−1 → c = max positive, c_sat=1; r < −2^(C_W−1) → c = most negative, c_sat=1; else c = r[C_W−1:0], c_sat=0. Defaults: range −8.0 … +7.5, step 0.5.
- sat_cnt increments on each output handshake (out_valid && out_ready) with c_sat=1; sticks at 2^CNT_W−1. cnt_clr has priority over a same-cycle increment (result 0, event dropped).

## Timing
- Whole pipeline advances when adv = !out_valid || out_ready; in_ready = adv (combinational from out_valid/out_ready); bubbles in stage 1 collapse only via this rule (stage 1 valid bit travels with data).
- Input handshake: in_valid && in_ready. Latency 2 cycles from input handshake to out_valid with out_ready held high; throughput 1/cycle.
- Stall: out_valid && !out_ready freezes both stages; c, c_sat held stable; in_ready=0.
- Reset (async assert, any time incl. mid-stream): stage valid bits, out_valid, c, c_sat, sat_cnt all 0; in-flight data discarded. First cycle after release: in_ready=1.
- Operands with in_valid=0 are ignored regardless of values.

## Structure
- Package fx_pkg: localparams/functions for F, I, D_W, S computation, sat_max/sat_min constants, and a signed-saturate function shared with the adder.
- Sub-module fx_round_sat (combinational: D_W input, round-half-up by S, clamp to C_W, sat flag); also reused by the adder. Top holds the two pipeline stages, handshake, counter.

## Test plan
- a=0x30 (3.0), b=6'b110100 (−1.5), out_ready=1 → 2 cycles later c=5'b01001 (4.5), c_sat=0.
- a=0x7F (7.9375), b=−32 (−4.0) → c=5'b01111 (7.5), c_sat=1, sat_cnt 0→1; a=−128 (−8.0), b=31 (3.875) → c=5'b10000 (−8.0), c_sat=1, sat_cnt=2.
- Rounding: a=4 (0.25), b=0 → c=1 (0.5); a=−4 (−0.25), b=0 → c=0; a=2 (0.125), b=0 → c=0.
- Backpressure: stream 6 pairs back-to-back, out_ready low for 3 cycles mid-stream → in_ready=0 during stall, c held, no loss/duplication, order preserved.
- Counter: force sat_cnt path to 0xFFFF → stays 0xFFFF on further saturations; cnt_clr coincident with saturated handshake → 0.
- Exhaustive sweep all a×b vs real-valued model (round-half-up, clamp −8…7.5); async rst mid-stream → out_valid=0, sat_cnt=0 immediately, no stale output after release.
